// File: rtl/ili9341_defs_pkg.sv
// rtl/ili9341_defs_pkg.sv - ILI9341 opcodes, D/CX levels, delay formulas and sequencer states.
package ili9341_defs;

  localparam logic [7:0] SW_RESET_CMD            = 8'h01;
  localparam logic [7:0] SLPOUT_CMD              = 8'h11;
  localparam logic [7:0] MADCTL_CMD              = 8'h36;
  localparam logic [7:0] COLMOD_CMD              = 8'h3A;
  localparam logic [7:0] DISPON_CMD              = 8'h29;
  localparam logic [7:0] READ_DISPLAY_STATUS_CMD = 8'h09;
  localparam logic [7:0] CASET_CMD               = 8'h2A;
  localparam logic [7:0] PASET_CMD               = 8'h2B;
  localparam logic [7:0] MEMWRITE_CMD            = 8'h2C;

  localparam logic COMMAND_BIT = 1'b0;
  localparam logic DATA_BIT    = 1'b1;

  typedef enum logic [2:0] {
    ST_RESET, ST_HW_HOLD, ST_DELAY, ST_SEND,
    ST_WAIT_BUSY, ST_WAIT_DONE, ST_MEM_REQ, ST_MEM_WAIT
  } state_e;

  function automatic logic [31:0] floor4(input logic [31:0] n);
    return (n < 32'd4) ? 32'd4 : n;
  endfunction

  function automatic logic [31:0] t_hold(input logic [31:0] f);
    return floor4(f / 32'd100000);
  endfunction

  function automatic logic [31:0] t_rel(input logic [31:0] f);
    return floor4(f / 32'd200);
  endfunction

  function automatic logic [31:0] t_swr(input logic [31:0] f);
    return floor4(f / 32'd200);
  endfunction

  function automatic logic [31:0] t_slp(input logic [31:0] f);
    return floor4(f / 32'd8);
  endfunction

endpackage

// File: rtl/ili9341_spi_controller_delay_timer.sv
// rtl/ili9341_spi_controller_delay_timer.sv - loadable down-counter shared by all delay states.
// Loads cycles-2 so the state that requested the load lasts exactly cycles_i clocks.
module ili9341_delay_timer (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic [31:0] cycles_i,
  output logic        done_o
);

  logic [31:0] count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= 32'd0;
    end else if (load_i) begin
      count_q <= cycles_i - 32'd2;
    end else if (count_q != 32'd0) begin
      count_q <= count_q - 32'd1;
    end
  end

  assign done_o = (count_q == 32'd0) && !load_i;

endmodule

// File: rtl/ili9341_spi_controller.sv
// rtl/ili9341_spi_controller.sv - ILI9341 bring-up sequencer and RGB565 frame streamer.
// STATUS_READ_EN enables the RDDST status read between DISPON and CASET.
module ili9341_spi_controller
  import ili9341_defs::*;
#(
  parameter int unsigned SYS_CLK_FREQ = 12000000,
  parameter int unsigned DISPLAY_X    = 320,
  parameter int unsigned DISPLAY_Y    = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_busy,
  input  logic [7:0]  spi_in,
  input  logic [7:0]  mem_in,
  input  logic        mem_ready,
  output logic        dis_reset,
  output logic        dc,
  output logic        spi_start,
  output logic [7:0]  spi_out,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  output logic [31:0] display_status
);

  localparam logic [31:0] T_HOLD    = t_hold(SYS_CLK_FREQ);
  localparam logic [31:0] T_REL     = t_rel(SYS_CLK_FREQ);
  localparam logic [31:0] T_SWR     = t_swr(SYS_CLK_FREQ);
  localparam logic [31:0] T_SLP     = t_slp(SYS_CLK_FREQ);
  localparam logic [15:0] X16       = 16'(DISPLAY_X);
  localparam logic [15:0] Y16       = 16'(DISPLAY_Y);
  localparam logic [31:0] LAST_ADDR = 32'(DISPLAY_X * DISPLAY_Y * 2 - 1);

  localparam logic [4:0] STEP_SWRESET = 5'd0;
  localparam logic [4:0] STEP_SLPOUT  = 5'd1;
  localparam logic [4:0] STEP_DISPON  = 5'd6;
  localparam logic [4:0] STEP_RD_1ST  = 5'd9;
  localparam logic [4:0] STEP_RD_LAST = 5'd12;
  localparam logic [4:0] STEP_CASET   = 5'd13;
  localparam logic [4:0] STEP_MEMWR   = 5'd23;

  state_e      state_q;
  logic [4:0]  step_q;
  logic        stream_q, dis_reset_q, dc_q, spi_start_q, mem_req_q, tmr_load_q;
  logic [7:0]  spi_out_q;
  logic [31:0] mem_addr_q, status_q, tmr_cycles_q;
  logic        tmr_done, step_dc_d;
  logic [7:0]  step_byte_d;

  ili9341_delay_timer u_timer (
    .clk_i    (clk),
    .reset_i  (reset),
    .load_i   (tmr_load_q),
    .cycles_i (tmr_cycles_q),
    .done_o   (tmr_done)
  );

  // Command script: steps 7..12 are the RDDST read, 13..23 the window setup.
  always_comb begin
    step_dc_d   = DATA_BIT;
    step_byte_d = 8'h00;
    case (step_q)
      5'd0:  begin step_dc_d = COMMAND_BIT; step_byte_d = SW_RESET_CMD; end
      5'd1:  begin step_dc_d = COMMAND_BIT; step_byte_d = SLPOUT_CMD; end
      5'd2:  begin step_dc_d = COMMAND_BIT; step_byte_d = MADCTL_CMD; end
      5'd3:  step_byte_d = 8'h28;
      5'd4:  begin step_dc_d = COMMAND_BIT; step_byte_d = COLMOD_CMD; end
      5'd5:  step_byte_d = 8'h55;
      5'd6:  begin step_dc_d = COMMAND_BIT; step_byte_d = DISPON_CMD; end
      5'd7:  begin step_dc_d = COMMAND_BIT; step_byte_d = READ_DISPLAY_STATUS_CMD; end
      5'd13: begin step_dc_d = COMMAND_BIT; step_byte_d = CASET_CMD; end
      5'd16: step_byte_d = X16[15:8];
      5'd17: step_byte_d = X16[7:0];
      5'd18: begin step_dc_d = COMMAND_BIT; step_byte_d = PASET_CMD; end
      5'd21: step_byte_d = Y16[15:8];
      5'd22: step_byte_d = Y16[7:0];
      5'd23: begin step_dc_d = COMMAND_BIT; step_byte_d = MEMWRITE_CMD; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RESET;
      step_q       <= STEP_SWRESET;
      stream_q     <= 1'b0;
      dis_reset_q  <= 1'b1;
      dc_q         <= COMMAND_BIT;
      spi_start_q  <= 1'b0;
      spi_out_q    <= 8'h00;
      mem_addr_q   <= 32'd0;
      mem_req_q    <= 1'b0;
      status_q     <= 32'd0;
      tmr_load_q   <= 1'b0;
      tmr_cycles_q <= 32'd0;
    end else begin
      spi_start_q <= 1'b0;
      mem_req_q   <= 1'b0;
      tmr_load_q  <= 1'b0;
      case (state_q)
        ST_RESET: begin
          dis_reset_q  <= 1'b0;
          tmr_load_q   <= 1'b1;
          tmr_cycles_q <= T_HOLD;
          state_q      <= ST_HW_HOLD;
        end
        ST_HW_HOLD: if (tmr_done) begin
          dis_reset_q  <= 1'b1;
          tmr_load_q   <= 1'b1;
          tmr_cycles_q <= T_REL;
          step_q       <= STEP_SWRESET;
          state_q      <= ST_DELAY;
        end
        ST_DELAY: if (tmr_done) state_q <= ST_SEND;
        ST_SEND: if (!spi_busy) begin
          spi_start_q <= 1'b1;
          if (!stream_q) begin
            dc_q      <= step_dc_d;
            spi_out_q <= step_byte_d;
          end
          state_q <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: if (spi_busy) state_q <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (!spi_busy) begin
          if (stream_q) begin
            if (mem_addr_q == LAST_ADDR) begin
              mem_addr_q <= 32'd0;
              stream_q   <= 1'b0;
              step_q     <= STEP_CASET;
              state_q    <= ST_SEND;
            end else begin
              mem_addr_q <= mem_addr_q + 32'd1;
              state_q    <= ST_MEM_REQ;
            end
          end else begin
            case (step_q)
              STEP_SWRESET: begin
                tmr_load_q <= 1'b1; tmr_cycles_q <= T_SWR;
                step_q <= STEP_SLPOUT; state_q <= ST_DELAY;
              end
              STEP_SLPOUT: begin
                tmr_load_q <= 1'b1; tmr_cycles_q <= T_SLP;
                step_q <= step_q + 5'd1; state_q <= ST_DELAY;
              end
              STEP_MEMWR: begin
                stream_q <= 1'b1; mem_addr_q <= 32'd0; state_q <= ST_MEM_REQ;
              end
              default: begin
                step_q <= step_q + 5'd1; state_q <= ST_SEND;
              end
            endcase
`ifdef STATUS_READ_EN
            if (step_q >= STEP_RD_1ST && step_q <= STEP_RD_LAST)
              status_q <= {status_q[23:0], spi_in};
`else
            if (step_q == STEP_DISPON) step_q <= STEP_CASET;
`endif
          end
        end
        ST_MEM_REQ: begin
          mem_req_q <= 1'b1;
          state_q   <= ST_MEM_WAIT;
        end
        ST_MEM_WAIT: if (mem_ready) begin
          spi_out_q <= mem_in;
          dc_q      <= DATA_BIT;
          state_q   <= ST_SEND;
        end
        default: state_q <= ST_RESET;
      endcase
    end
  end

  assign dis_reset      = dis_reset_q;
  assign dc             = dc_q;
  assign spi_start      = spi_start_q;
  assign spi_out        = spi_out_q;
  assign mem_addr       = mem_addr_q;
  assign mem_req        = mem_req_q;
  assign display_status = status_q;

endmodule

// File: tb/tb_ili9341_spi_controller.sv
// tb/tb_ili9341_spi_controller.sv - directed bench with SPI/memory mocks and a start-event log.
module tb_ili9341_spi_controller;

  typedef struct {
    logic        dc;
    logic [7:0]  b;
    logic [31:0] addr;
    int          cyc;
    logic [31:0] st;
  } start_t;

  typedef struct {
    logic [8:0]  dcb;
    logic        chk_addr;
    logic [31:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_busy = 1'b0;
  logic [7:0]  spi_in = 8'h00;
  logic [7:0]  mem_in = 8'h00;
  logic        mem_ready = 1'b0;
  logic        dis_reset, dc, spi_start, mem_req;
  logic [7:0]  spi_out;
  logic [31:0] mem_addr, display_status;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rel_cyc = 0, fall_cyc = -1, rise_cyc = -1;
  logic prev_dis = 1'b1;
  start_t log_q[$];
  exp_t   exp_q[$];

  int   spi_cnt = 0;
  logic spi_pend = 1'b0;
  logic mem_pend = 1'b0;

  ili9341_spi_controller #(
    .SYS_CLK_FREQ (1),
    .DISPLAY_X    (3),
    .DISPLAY_Y    (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .spi_busy       (spi_busy),
    .spi_in         (spi_in),
    .mem_in         (mem_in),
    .mem_ready      (mem_ready),
    .dis_reset      (dis_reset),
    .dc             (dc),
    .spi_start      (spi_start),
    .spi_out        (spi_out),
    .mem_addr       (mem_addr),
    .mem_req        (mem_req),
    .display_status (display_status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [7:0] pat(input logic [31:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return lo * 8'd7 + 8'h13;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic d, input logic [7:0] b, input logic ca, input logic [31:0] a);
    exp_t e;
    e.dcb = {d, b};
    e.chk_addr = ca;
    e.addr = a;
    exp_q.push_back(e);
  endtask

  // SPI mock: busy one cycle after spi_start, for three cycles, returning 0xAA.
  always @(negedge clk) begin
    if (reset) begin
      spi_busy = 1'b0; spi_cnt = 0; spi_pend = 1'b0;
    end else if (spi_pend) begin
      spi_pend = 1'b0; spi_busy = 1'b1; spi_cnt = 3;
    end else if (spi_busy) begin
      if (spi_cnt == 1) begin
        spi_busy = 1'b0; spi_in = 8'hAA;
      end
      spi_cnt--;
    end
    if (!reset && spi_start) spi_pend = 1'b1;
  end

  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (mem_pend) begin
      mem_ready = 1'b1;
      mem_in = pat(mem_addr);
    end
    mem_pend = !reset && mem_req;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (prev_dis && !dis_reset && fall_cyc < 0) fall_cyc = cyc;
      if (!prev_dis && dis_reset && rise_cyc < 0) rise_cyc = cyc;
      if (spi_start) begin
        start_t s;
        s.dc = dc; s.b = spi_out; s.addr = mem_addr; s.cyc = cyc; s.st = display_status;
        log_q.push_back(s);
      end
    end
    prev_dis = dis_reset;
  end

  initial begin
    int n_need, n_cmp, caset_idx;
    logic [31:0] exp_status;

    push_exp(1'b0, 8'h01, 1'b0, 0);
    push_exp(1'b0, 8'h11, 1'b0, 0);
    push_exp(1'b0, 8'h36, 1'b0, 0);
    push_exp(1'b1, 8'h28, 1'b0, 0);
    push_exp(1'b0, 8'h3A, 1'b0, 0);
    push_exp(1'b1, 8'h55, 1'b0, 0);
    push_exp(1'b0, 8'h29, 1'b0, 0);
`ifdef STATUS_READ_EN
    push_exp(1'b0, 8'h09, 1'b0, 0);
    for (int i = 0; i < 5; i++) push_exp(1'b1, 8'h00, 1'b0, 0);
    exp_status = 32'hAAAAAAAA;
`else
    exp_status = 32'h0;
`endif
    caset_idx = exp_q.size();
    push_exp(1'b0, 8'h2A, 1'b0, 0);
    push_exp(1'b1, 8'h00, 1'b0, 0);
    push_exp(1'b1, 8'h00, 1'b0, 0);
    push_exp(1'b1, 8'h00, 1'b0, 0);
    push_exp(1'b1, 8'h03, 1'b0, 0);
    push_exp(1'b0, 8'h2B, 1'b0, 0);
    push_exp(1'b1, 8'h00, 1'b0, 0);
    push_exp(1'b1, 8'h00, 1'b0, 0);
    push_exp(1'b1, 8'h00, 1'b0, 0);
    push_exp(1'b1, 8'h04, 1'b0, 0);
    push_exp(1'b0, 8'h2C, 1'b0, 0);
    for (int a = 0; a < 24; a++) push_exp(1'b1, pat(32'(a)), 1'b1, 32'(a));
    push_exp(1'b0, 8'h2A, 1'b1, 0);
    n_need = exp_q.size();

    repeat (3) @(negedge clk);
    check_eq("rst_dis_reset", {31'd0, dis_reset}, 32'd1);
    check_eq("rst_dc", {31'd0, dc}, 32'd0);
    check_eq("rst_spi_start", {31'd0, spi_start}, 32'd0);
    check_eq("rst_spi_out", {24'd0, spi_out}, 32'd0);
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_status", display_status, 32'd0);

    rel_cyc = cyc;
    reset = 1'b0;

    for (int i = 0; i < 5000 && log_q.size() < n_need; i++) @(negedge clk);
    check_eq("log_len", {31'd0, log_q.size() >= n_need}, 32'd1);

    check_eq("dis_fall_delay", 32'(fall_cyc - rel_cyc), 32'd1);
    check_eq("dis_low_cycles", 32'(rise_cyc - fall_cyc), 32'd4);
    if (log_q.size() >= 3) begin
      check_eq("swreset_gap_gt4", {31'd0, (log_q[0].cyc - rise_cyc) > 4}, 32'd1);
      check_eq("slpout_gap_gt4", {31'd0, (log_q[1].cyc - log_q[0].cyc) > 4}, 32'd1);
      check_eq("madctl_gap_gt4", {31'd0, (log_q[2].cyc - log_q[1].cyc) > 4}, 32'd1);
    end
    if (log_q.size() > caset_idx)
      check_eq("status_at_caset", log_q[caset_idx].st, exp_status);

    n_cmp = (log_q.size() < n_need) ? log_q.size() : n_need;
    for (int i = 0; i < n_cmp; i++) begin
      check_eq($sformatf("start%0d_dc_byte", i), {23'd0, log_q[i].dc, log_q[i].b}, {23'd0, exp_q[i].dcb});
      if (exp_q[i].chk_addr)
        check_eq($sformatf("start%0d_addr", i), log_q[i].addr, exp_q[i].addr);
    end

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_dis_reset", {31'd0, dis_reset}, 32'd1);
    check_eq("midrst_dc", {31'd0, dc}, 32'd0);
    check_eq("midrst_spi_out", {24'd0, spi_out}, 32'd0);
    check_eq("midrst_mem_addr", mem_addr, 32'd0);
    check_eq("midrst_status", display_status, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
